// File: rtl/waveform_shaper.sv
// waveform_shaper: streaming per-frame sample shaper (pass, slew-limited triangle, hysteretic square, pseudo-FM)
// Ports: clk, rst_n (sync, active-low); start/sw begin a frame and pick its mode;
//        in_valid/in_ready/in_data input stream; out_valid/out_ready/out_data/out_last output stream;
//        busy while a frame runs; done pulses after the last output handshake; rdy_flg sticky frame-complete flag.
module waveform_shaper #(
   parameter int DATA_W        = 8,
   parameter int FRAME_LEN     = 256,
   parameter int SLEW_STEP     = 2,
   parameter int HYST          = 8,
   parameter int FM_MAX_PERIOD = 51
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [3:0]        sw,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              rdy_flg
);
   localparam int MAXV = 2**DATA_W - 1;
   localparam int MID  = 2**(DATA_W-1);
   localparam int HI_T = (MID + HYST > MAXV) ? MAXV : MID + HYST;
   localparam int LO_T = (MID - HYST < 0) ? 0 : MID - HYST;
   localparam int CW   = $clog2(FRAME_LEN + 1);
   localparam int PW   = $clog2(FM_MAX_PERIOD + 1);
   localparam int MW   = DATA_W + $clog2(FM_MAX_PERIOD);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nx;
   logic [3:0] mode_q;
   logic [CW-1:0] cnt;
   logic [DATA_W-1:0] t_q, t_nx, y;
   logic [DATA_W:0] t_up, t_dn;
   logic s_q, s_nx, bit_q, bit_nx, fm_hit;
   logic [PW-1:0] pos_q, pos_inc, fm_step;
   logic [MW-1:0] fm_q;
   logic start_ok, acc, last_hs, first;
   assign busy     = state == RUN;
   assign start_ok = !busy && start;
   assign in_ready = busy && cnt < CW'(FRAME_LEN) && (!out_valid || out_ready);
   assign acc      = in_valid && in_ready;
   assign last_hs  = busy && out_valid && out_ready && out_last;
   assign first    = cnt == '0;
   always_comb begin
      state_nx = state == IDLE ? (start ? RUN : IDLE) : (last_hs ? IDLE : RUN);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end
   always_comb begin
      t_up    = {1'b0, t_q} + (DATA_W+1)'(SLEW_STEP);
      // a borrow in t_dn means the step would go below zero, so the input is the floor
      t_dn    = {1'b0, t_q} - (DATA_W+1)'(SLEW_STEP);
      t_nx    = first ? in_data
              : in_data > t_q ? (t_up > {1'b0, in_data} ? in_data : t_up[DATA_W-1:0])
              : in_data < t_q ? ((t_dn[DATA_W] || t_dn < {1'b0, in_data}) ? in_data : t_dn[DATA_W-1:0])
              : t_q;
      s_nx    = first ? in_data >= DATA_W'(MID)
              : s_q ? in_data >= DATA_W'(LO_T) : in_data >= DATA_W'(HI_T);
      fm_q    = MW'(in_data) * MW'(FM_MAX_PERIOD - 1) / MW'(MAXV);
      fm_step = PW'(FM_MAX_PERIOD) - PW'(fm_q);
      pos_inc = pos_q + PW'(1);
      fm_hit  = pos_inc >= fm_step;
      bit_nx  = bit_q ^ fm_hit;
      y       = mode_q == 4'b0001 ? in_data
              : mode_q == 4'b0010 ? t_nx
              : mode_q == 4'b0100 ? {DATA_W{s_nx}}
              : mode_q == 4'b1000 ? {DATA_W{bit_nx}}
              : '0;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q    <= '0;
         cnt       <= '0;
         t_q       <= '0;
         s_q       <= 1'b0;
         pos_q     <= '0;
         bit_q     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
         rdy_flg   <= 1'b0;
      end else begin
         done <= last_hs;
         if (last_hs)       rdy_flg <= 1'b1;
         else if (start_ok) rdy_flg <= 1'b0;
         if (start_ok) begin
            mode_q <= sw;
            cnt    <= '0;
            t_q    <= '0;
            s_q    <= 1'b0;
            pos_q  <= '0;
            bit_q  <= 1'b0;
         end else if (acc) begin
            cnt   <= cnt + 1'b1;
            t_q   <= t_nx;
            s_q   <= s_nx;
            pos_q <= fm_hit ? '0 : pos_inc;
            bit_q <= bit_nx;
         end
         if (acc) begin
            out_valid <= 1'b1;
            out_data  <= y;
            out_last  <= cnt == CW'(FRAME_LEN - 1);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_waveform_shaper.sv
// tb_waveform_shaper: randomized frames checked every cycle against a behavioural model, plus literal pins
module tb_waveform_shaper;
   localparam int DW = 8, FL = 128, SLEW = 2, HYS = 8, FMP = 51, MAXV = 255, MID = 128;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [3:0] sw = '0;
   logic [DW-1:0] in_data = '0;
   logic in_ready, out_valid, out_last, busy, done, rdy_flg;
   logic [DW-1:0] out_data;
   always #5 clk = ~clk;
   waveform_shaper #(.DATA_W(DW), .FRAME_LEN(FL), .SLEW_STEP(SLEW), .HYST(HYS), .FM_MAX_PERIOD(FMP)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sw(sw),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done), .rdy_flg(rdy_flg));
   int checks = 0, errors = 0;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask
   typedef struct {int d; bit l;} exp_t;
   exp_t q[$];
   exp_t e;
   bit armed = 0, running = 0, done_e = 0, rdy_e = 0, rst_chk = 0, ir, hs, lh;
   int mcnt = 0, m_mode = 0, m_t = 0, m_s = 0, m_pos = 0, m_bit = 0, ocnt = 0;
   int got [FL];
   int stim [FL];
   function automatic int shape(input int x);
      int step;
      if (mcnt == 0) begin
         m_t = x;
         m_s = x >= MID ? 1 : 0;
      end else begin
         if (x > m_t)      m_t = (m_t + SLEW > x) ? x : m_t + SLEW;
         else if (x < m_t) m_t = (m_t - SLEW < x) ? x : m_t - SLEW;
         if (m_s == 0 && x >= MID + HYS)     m_s = 1;
         else if (m_s == 1 && x < MID - HYS) m_s = 0;
      end
      step = FMP - (x * (FMP - 1)) / MAXV;
      m_pos++;
      if (m_pos >= step) begin
         m_bit = 1 - m_bit;
         m_pos = 0;
      end
      case (m_mode)
         1: return x;
         2: return m_t;
         4: return m_s ? MAXV : 0;
         8: return m_bit ? MAXV : 0;
         default: return 0;
      endcase
   endfunction
   always @(negedge clk) begin
      if (armed) begin
         chk("busy", busy, running);
         chk("done", done, done_e);
         chk("rdy_flg", rdy_flg, rdy_e);
         chk("out_valid", out_valid, q.size() > 0);
         chk("in_ready", in_ready, running && mcnt < FL && (q.size() == 0 || out_ready));
         if (q.size() > 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_last", out_last, q[0].l);
         end
         if (rst_chk) begin
            chk("reset_out_data", out_data, 0);
            chk("reset_out_last", out_last, 0);
         end
      end
      rst_chk = 0;
      if (!rst_n) begin
         armed = 1; running = 0; done_e = 0; rdy_e = 0; mcnt = 0; rst_chk = 1;
         q.delete();
      end else if (armed) begin
         ir = running && mcnt < FL && (q.size() == 0 || out_ready);
         hs = q.size() > 0 && out_ready;
         lh = hs && q[0].l;
         done_e = lh;
         if (hs) begin
            if (ocnt < FL) got[ocnt] = q[0].d;
            ocnt++;
            void'(q.pop_front());
         end
         if (in_valid && ir) begin
            e.l = mcnt == FL - 1;
            e.d = shape(int'(in_data));
            q.push_back(e);
            mcnt++;
         end
         if (lh) begin
            running = 0;
            rdy_e = 1;
         end else if (!running && start) begin
            running = 1; m_mode = int'(sw); mcnt = 0; m_pos = 0; m_bit = 0; ocnt = 0; rdy_e = 0;
         end
      end
   end
   task automatic run_frame(input logic [3:0] m, input int vp, input int rp, input int stall_at,
                            input int abort_at, input bit exp_done);
      int k = 0, cyc = 0;
      bit acc, dseen = 0;
      sw = m;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (!dseen && cyc < 6000) begin
         if (abort_at >= 0 && k >= abort_at) begin
            rst_n = 1'b0; in_valid = 1'b0; start = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            break;
         end
         in_valid  = k < FL && $urandom_range(99) < vp;
         in_data   = DW'(stim[k < FL ? k : 0]);
         out_ready = (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5) ? 1'b0 : $urandom_range(99) < rp;
         sw        = 4'($urandom);
         start     = !done && $urandom_range(99) < 20;
         @(negedge clk);
         acc   = in_valid && in_ready;
         dseen = done;
         @(posedge clk); #1;
         if (acc) k++;
         cyc++;
      end
      in_valid = 1'b0;
      start = 1'b0;
      if (exp_done) chk("frame_done", dseen, 1);
   endtask
   task automatic fill_rand();
      for (int i = 0; i < FL; i++) stim[i] = $urandom_range(255);
   endtask
   initial begin
      logic [3:0] modes [5];
      modes = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0110};
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_rdy", rdy_flg, 0);
      rst_n = 1'b1;
      fill_rand();
      stim[0] = 0; stim[1] = 77; stim[2] = 128; stim[3] = 255;
      run_frame(4'b0001, 100, 100, -1, -1, 1);
      chk("pass0", got[0], 0);
      chk("pass1", got[1], 77);
      chk("pass2", got[2], 128);
      chk("pass3", got[3], 255);
      chk("pass_rdy_flg", rdy_flg, 1);
      fill_rand();
      stim[0] = 10; stim[1] = 20; stim[2] = 20; stim[3] = 5;
      run_frame(4'b0010, 100, 100, -1, -1, 1);
      chk("tri0", got[0], 10);
      chk("tri1", got[1], 12);
      chk("tri2", got[2], 14);
      chk("tri3", got[3], 12);
      fill_rand();
      stim[0] = 100; stim[1] = 130; stim[2] = 136; stim[3] = 130; stim[4] = 119; stim[5] = 121;
      run_frame(4'b0100, 100, 100, -1, -1, 1);
      chk("sq0", got[0], 0);
      chk("sq1", got[1], 0);
      chk("sq2", got[2], 255);
      chk("sq3", got[3], 255);
      chk("sq4", got[4], 0);
      chk("sq5", got[5], 0);
      for (int i = 0; i < FL; i++) stim[i] = 255;
      run_frame(4'b1000, 100, 100, -1, -1, 1);
      chk("fm_hi0", got[0], 255);
      chk("fm_hi1", got[1], 0);
      chk("fm_hi2", got[2], 255);
      chk("fm_hi3", got[3], 0);
      for (int i = 0; i < FL; i++) stim[i] = 0;
      run_frame(4'b1000, 100, 100, -1, -1, 1);
      chk("fm_lo0", got[0], 0);
      chk("fm_lo49", got[49], 0);
      chk("fm_lo50", got[50], 255);
      chk("fm_lo100", got[100], 255);
      chk("fm_lo101", got[101], 0);
      fill_rand();
      run_frame(4'b0001, 100, 100, 30, -1, 1);
      fill_rand();
      run_frame(4'b0010, 100, 100, -1, 3, 0);
      chk("abort_busy", busy, 0);
      chk("abort_rdy", rdy_flg, 0);
      chk("abort_out_valid", out_valid, 0);
      fill_rand();
      run_frame(4'b0100, 70, 70, -1, -1, 1);
      fill_rand();
      run_frame(4'b0011, 80, 80, -1, -1, 1);
      chk("bad_mode0", got[0], 0);
      chk("bad_mode_last", got[FL-1], 0);
      for (int f = 0; f < 8; f++) begin
         fill_rand();
         run_frame(modes[$urandom_range(4)], $urandom_range(100, 30), $urandom_range(100, 30), -1, -1, 1);
      end
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/waveform_shaper.md
# waveform_shaper

Parametrised streaming successor to the frame-based waveform converter. Accepts one quantised sample per handshake over a FRAME_LEN-sample frame and emits the shaped sample one cycle later. Modes: pass-through, slew-limited triangle, hysteretic square and pseudo-FM, with ready/valid backpressure on both sides. It sits between the quantised-sine source and the digital filter input.

## Interface
- DATA_W, 8, sample width (unsigned); MAX = 2^DATA_W-1, MID = 2^(DATA_W-1)
- FRAME_LEN, 256, samples per frame (≥2)
- SLEW_STEP, 2, triangle max change per sample
- HYST, 8, square hysteresis half-band around MID
- FM_MAX_PERIOD, 51, FM toggle period for input 0 (period 1 at input MAX)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin frame; honoured only in IDLE
- sw  in  4  one-hot mode: 0001 pass, 0010 triangle, 0100 square, 1000 FM; any other value = zero output
- in_valid  in  1  / in_ready  out  1  / in_data  in  DATA_W: input stream
- out_valid  out  1  / out_ready  in  1  / out_data  out  DATA_W: output stream
- out_last  out  1  qualifies final sample of frame
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after last output handshake
- rdy_flg  out  1  sticky: set with done, cleared by accepted start

## Operation
- FSM IDLE→RUN on start (sw latched into mode_q, sample counter, trackers, FM state cleared). RUN→IDLE on the edge where out_valid&&out_ready&&out_last; done=1 and rdy_flg=1 from that edge for one cycle (rdy_flg stays).
- start in RUN ignored; sw changes in RUN ignored.
- in_ready = RUN && count<FRAME_LEN && (!out_valid || out_ready). Input accept → out_data/out_valid registered next edge; out_last=1 when accepted sample index = FRAME_LEN-1.
- Output holds (out_data, out_last stable) while out_valid && !out_ready.
- Pass: y = x.
- Triangle: first sample t=x, y=x. Then x>t: t=min(t+SLEW_STEP, x); x<t: t=max(t-SLEW_STEP, x); equal: hold. y=t. Arithmetic DATA_W+1 bits, no wrap.
- Square: first sample s = (x≥MID). Then s=0 and x≥MID+HYST → s=1; s=1 and x<MID-HYST → s=0. y = s ? MAX : 0. Thresholds clamped to [0, MAX].
- FM: step = FM_MAX_PERIOD - (x·(FM_MAX_PERIOD-1))/MAX (integer division, product width DATA_W+clog2(FM_MAX_PERIOD)). Per sample pos=pos+1; if pos≥step: bit=~bit, pos=0. y = bit ? MAX : 0 (uses updated bit). pos=0, bit=0 at frame start.
- Invalid mode: y=0, frame still counts and completes.

## Timing
- Reset (rst_n low at an edge): state IDLE, in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, rdy_flg=0, all trackers cleared. Mid-frame reset aborts the frame; no done.
- Latency: 1 cycle input accept → out_valid. Full throughput 1 sample/cycle with out_ready held high.
- busy rises the edge after start accepted; in_ready earliest the same cycle busy is high.
- Simultaneous: last output handshake and start in the same cycle → start ignored (state still RUN). start accepted the cycle after done.
- Out register capture and drain in the same cycle allowed (pipelined, no bubble).

## Test plan
- Pass, FRAME_LEN=4, inputs 0,77,128,255, out_ready=1 → outputs 0,77,128,255, out_last on 4th, done pulse 1 cycle later, rdy_flg=1.
- Triangle SLEW_STEP=2, inputs 10,20,20,5 → 10,12,14,12.
- Square HYST=8, inputs 100,130,136,130,119,121 → 0,0,255,255,0,0.
- FM FRAME_LEN=256: constant 255 → 255,0,255,0,…; constant 0 → indices 0–49 = 0, index 50 = 255, index 101 = 0.
- Backpressure: out_ready low 5 cycles mid-frame → in_ready low, out_data/out_last stable, no sample lost or duplicated vs. model.
- Reset at sample 3 of a triangle frame → next cycle all outputs 0/IDLE; new start with sw=0100 gives correct square output from sample 0, sw=0011 gives all-zero frame with done.
